adder_arbiter: RTL and testbench

- Shares one N-bit adder between two requesters using a valid/ready handshake on each port.
- Grants one requester per cycle; the adder computes A+B on the granted operands.
- The sum, carry and requester ID are captured in a single-entry result register with its own valid/ready handshake.
- Sits between the datapath clients (e.g. PC-increment and branch-target logic in a multi-cycle CPU) and the shared catalog adder.

---
 rtl/adder_arbiter.sv | 62 ++++++
 tb/tb_adder_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: two-requester valid/ready arbiter sharing one N-bit adder into a single-entry result register.
// Define ADDER_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to requester 0.
module adder_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_carry,
  output logic         res_id
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t       state_q;
  logic [N-1:0] data_q;
  logic         carry_q, id_q;
  logic         slot_free, win, acc;
  logic [N:0]   sum_d;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
  logic ptr_q;
  assign win = &req_valid ? ptr_q : req_valid[1];
`else
  assign win = !req_valid[0];
`endif
  assign slot_free = state_q == EMPTY || res_ready;
  // rst gates the grant so req_ready drops asynchronously with the reset
  assign acc       = slot_free && |req_valid && !rst;
  assign req_ready = acc ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign sum_d     = win ? {1'b0, req1_a} + {1'b0, req1_b} : {1'b0, req0_a} + {1'b0, req0_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= 1'b0;
`endif
    end else if (acc) begin
      state_q <= FULL;
      data_q  <= sum_d[N-1:0];
      carry_q <= sum_d[N];
      id_q    <= win;
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      ptr_q   <= ~win;
`endif
    end else if (res_ready) begin
      state_q <= EMPTY;
    end
  end
  assign res_valid = state_q == FULL;
  assign res_data  = data_q;
  assign res_carry = carry_q;
  assign res_id    = id_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors with hand-computed sums for adder_arbiter (N=8).
module tb_adder_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       res_valid, res_ready = 1'b1;
  logic [7:0] res_data;
  logic       res_carry, res_id;
  int         n_cmp = 0, n_bad = 0;

  adder_arbiter #(.N(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_carry(res_carry), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = 2'b01;
    #2;
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_data", 32'(res_data), 0);
    req_valid = 2'b00;
    #10 rst = 1'b0;
    tick;
    req0_a = 8'h12; req0_b = 8'h34; req_valid = 2'b01;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick;
    chk("single_data", 32'(res_data), 32'h46);
    chk("single_carry", 32'(res_carry), 0);
    chk("single_id", 32'(res_id), 0);
    chk("single_valid", 32'(res_valid), 1);
    req1_a = 8'hFF; req1_b = 8'h01; req_valid = 2'b10;
    #1 chk("wrap_ready", 32'(req_ready), 32'h2);
    tick;
    chk("wrap_data", 32'(res_data), 32'h00);
    chk("wrap_carry", 32'(res_carry), 1);
    chk("wrap_id", 32'(res_id), 1);
    req0_a = 8'h01; req0_b = 8'h01; req1_a = 8'h02; req1_b = 8'h02; req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
      #1 chk("cont_ready", 32'(req_ready), (i % 2) ? 32'h2 : 32'h1);
      tick;
      chk("cont_id", 32'(res_id), i % 2);
      chk("cont_data", 32'(res_data), (i % 2) ? 32'h4 : 32'h2);
`else
      #1 chk("cont_ready", 32'(req_ready), 32'h1);
      tick;
      chk("cont_id", 32'(res_id), 0);
      chk("cont_data", 32'(res_data), 32'h2);
`endif
      chk("cont_valid", 32'(res_valid), 1);
    end
    req_valid = 2'b00;
    tick;
    chk("drain_valid", 32'(res_valid), 0);
`ifdef ADDER_ARBITER_ROUND_ROBIN_EN
    chk("drain_hold", 32'(res_data), 32'h4);
`else
    chk("drain_hold", 32'(res_data), 32'h2);
`endif
    req_valid = 2'b11;
    #1 chk("drain_ptr", 32'(req_ready), 32'h1);
    req0_a = 8'h05; req0_b = 8'h03; req_valid = 2'b01;
    tick;
    chk("bp_fill", 32'(res_data), 32'h08);
    res_ready = 1'b0; req0_a = 8'h10; req0_b = 8'h20;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", 32'(req_ready), 0);
      tick;
      chk("bp_data", 32'(res_data), 32'h08);
      chk("bp_valid", 32'(res_valid), 1);
    end
    res_ready = 1'b1;
    #1 chk("bp_release", 32'(req_ready), 32'h1);
    tick;
    chk("bp_new", 32'(res_data), 32'h30);
    chk("bp_new_valid", 32'(res_valid), 1);
    req1_a = 8'hFF; req1_b = 8'h01; req_valid = 2'b10;
    tick;
    chk("pre_rst_carry", 32'(res_carry), 1);
    res_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_data", 32'(res_data), 0);
    chk("mid_rst_carry", 32'(res_carry), 0);
    chk("mid_rst_id", 32'(res_id), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
